// File: rtl/instruction_fetch_memory.sv
// Loadable instruction memory for the fetch stage: streaming sequential load, registered fetch, NOP + fault on out-of-range.
// Latency: fetch result registered one cycle after FetchReq; load words are written on the cycle LoadValid is sampled.
// Backpressure: Stall holds every fetch output and drops FetchReq; the load port has no flow control (every LoadValid in LOAD is taken).
// Optional feature macro: IMEM_PARITY_EN (adds a stored even-parity bit per word and checks it on fetch).
module instruction_fetch_memory #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  LoadStart,
    input  logic                  LoadValid,
    input  logic [DATA_WIDTH-1:0] LoadData,
    input  logic                  LoadLast,
    input  logic                  ParityInject,
    input  logic                  FetchReq,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  Stall,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  InstrValid,
    output logic                  AddrFault,
    output logic                  ParityErr,
    output logic                  Ready,
    output logic [ADDR_WIDTH:0]   WordCount
);

    localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   count;
    logic [MEM_W-1:0]      mem [DEPTH];
    logic [MEM_W-1:0]      wr_word;
    logic [MEM_W-1:0]      rd_word;
    logic                  wr_en;
    logic                  last_slot;
    logic                  in_range;
    logic                  rd_perr;
    logic                  fetch_en;

    // The write pointer is the low bits of the word count; the two always move together.
    assign last_slot = (count == (ADDR_WIDTH+1)'(DEPTH - 1));
    assign wr_en     = (state == LOAD) && !LoadStart && LoadValid;
    assign rd_word   = mem[Address];
    assign in_range  = ({1'b0, Address} < count);
    // A LoadStart cycle takes priority over any fetch presented alongside it.
    assign fetch_en  = (state == READY) && !LoadStart;

`ifdef IMEM_PARITY_EN
    // Stored bit makes the word even-parity; ParityInject corrupts it for error-path testing.
    assign wr_word = {(^LoadData) ^ ParityInject, LoadData};
    assign rd_perr = ^rd_word;
`else
    logic unused_parity_inject;
    assign unused_parity_inject = ParityInject;
    assign wr_word = LoadData;
    assign rd_perr = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state: LoadStart always (re)arms a load; LOAD ends on LoadLast or when the array fills.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (LoadStart) state_nxt = LOAD;
            LOAD: begin
                if (LoadStart)                               state_nxt = LOAD;
                else if ((LoadValid && last_slot) || LoadLast) state_nxt = READY;
            end
            READY: if (LoadStart) state_nxt = LOAD;
            default: state_nxt = EMPTY;
        endcase
    end

    // Word count / write pointer: cleared on every LoadStart, advanced per accepted load word.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)          count <= '0;
        else if (LoadStart) count <= '0;
        else if (wr_en)     count <= count + 1'b1;
    end

    // Storage array is deliberately not reset; WordCount gates what is fetchable.
    always_ff @(posedge Clk) begin
        if (wr_en) mem[count[ADDR_WIDTH-1:0]] <= wr_word;
    end

    // Fetch output register: cleared outside READY, frozen under Stall, else one result per request.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Instruction <= '0;
            InstrValid  <= 1'b0;
            AddrFault   <= 1'b0;
            ParityErr   <= 1'b0;
        end else if (!fetch_en) begin
            InstrValid  <= 1'b0;
            AddrFault   <= 1'b0;
            ParityErr   <= 1'b0;
        end else if (!Stall) begin
            InstrValid  <= FetchReq;
            AddrFault   <= 1'b0;
            ParityErr   <= 1'b0;
            if (FetchReq) begin
                if (in_range) begin
                    Instruction <= rd_word[DATA_WIDTH-1:0];
                    ParityErr   <= rd_perr;
                end else begin
                    Instruction <= NOP_WORD;
                    AddrFault   <= 1'b1;
                end
            end
        end
    end

    assign Ready     = (state == READY);
    assign WordCount = count;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench for instruction_fetch_memory: load, fetch, fault, stall, auto-fill, reset-mid-load, parity.
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point after the next edge.
// Each comparison goes through check(); summary line reports totals.
module tb_instruction_fetch_memory;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          LoadStart, LoadValid, LoadLast, ParityInject;
    logic [DW-1:0] LoadData;
    logic          FetchReq, Stall;
    logic [AW-1:0] Address;
    logic [DW-1:0] Instruction;
    logic          InstrValid, AddrFault, ParityErr, Ready;
    logic [AW:0]   WordCount;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] prog [4];
    logic          exp_perr;

    instruction_fetch_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadLast(LoadLast), .ParityInject(ParityInject),
        .FetchReq(FetchReq), .Address(Address), .Stall(Stall),
        .Instruction(Instruction), .InstrValid(InstrValid), .AddrFault(AddrFault),
        .ParityErr(ParityErr), .Ready(Ready), .WordCount(WordCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        LoadStart = 0; LoadValid = 0; LoadLast = 0; ParityInject = 0;
        LoadData = '0; FetchReq = 0; Stall = 0; Address = '0;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        FetchReq = 1; Address = a;
        tick();
        FetchReq = 0;
    endtask

    task automatic start_load();
        LoadStart = 1;
        tick();
        LoadStart = 0;
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last, input logic inj);
        LoadValid = 1; LoadData = d; LoadLast = last; ParityInject = inj;
        tick();
        LoadValid = 0; LoadLast = 0; ParityInject = 0;
    endtask

    initial begin
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0007;
        prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
        idle_inputs();
        Reset = 1;
        #12;
        check("rst_instr",  Instruction, 0);
        check("rst_valid",  InstrValid, 0);
        check("rst_fault",  AddrFault, 0);
        check("rst_perr",   ParityErr, 0);
        check("rst_ready",  Ready, 0);
        check("rst_wcount", WordCount, 0);
        @(posedge Clk); #1;
        Reset = 0;

        // Fetch in EMPTY is ignored.
        fetch(0);
        check("empty_fetch_valid", InstrValid, 0);

        // LoadStart cycle ignores a simultaneous LoadValid.
        LoadStart = 1; LoadValid = 1; LoadData = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        check("arm_ignores_valid", WordCount, 0);
        check("arm_not_ready", Ready, 0);

        // Four-word program, LoadLast on the 4th.
        for (int i = 0; i < 4; i++) load_word(prog[i], i == 3, 1'b0);
        check("prog_ready",  Ready, 1);
        check("prog_wcount", WordCount, 4);

        for (int i = 0; i < 4; i++) begin
            fetch(AW'(i));
            check($sformatf("fetch%0d_instr", i), Instruction, prog[i]);
            check($sformatf("fetch%0d_valid", i), InstrValid, 1);
            check($sformatf("fetch%0d_fault", i), AddrFault, 0);
            check($sformatf("fetch%0d_perr", i),  ParityErr, 0);
        end

        // No request: valid drops, instruction holds.
        tick();
        check("idle_valid", InstrValid, 0);
        check("idle_instr", Instruction, prog[3]);

        // Out-of-range fetches.
        fetch(4);
        check("oor4_instr", Instruction, 0);
        check("oor4_fault", AddrFault, 1);
        check("oor4_valid", InstrValid, 1);
        fetch(127);
        check("oor127_instr", Instruction, 0);
        check("oor127_fault", AddrFault, 1);
        fetch(2);
        check("after_fault_clear", AddrFault, 0);

        // Stall holds outputs and drops the request.
        fetch(1);
        check("pre_stall_instr", Instruction, prog[1]);
        Stall = 1; FetchReq = 1; Address = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_instr", i), Instruction, prog[1]);
            check($sformatf("stall%0d_valid", i), InstrValid, 1);
        end
        Stall = 0;
        tick();
        FetchReq = 0;
        check("unstall_instr", Instruction, prog[2]);

        // LoadStart in READY: fetch dropped, valid cleared even under Stall.
        LoadStart = 1; FetchReq = 1; Address = 0; Stall = 1;
        tick();
        idle_inputs();
        check("reload_valid",  InstrValid, 0);
        check("reload_ready",  Ready, 0);
        check("reload_wcount", WordCount, 0);

        // Fill all 128 words without LoadLast.
        for (int i = 0; i < 128; i++) begin
            load_word(DW'(i), 1'b0, 1'b0);
            if (i == 126) begin
                check("fill127_wcount", WordCount, 127);
                check("fill127_ready",  Ready, 0);
            end
        end
        check("full_ready",  Ready, 1);
        check("full_wcount", WordCount, 128);
        load_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        check("extra_wcount", WordCount, 128);
        fetch(127);
        check("full_fetch127", Instruction, 127);
        check("full_fault127", AddrFault, 0);
        fetch(0);
        check("full_fetch0", Instruction, 0);

        // Reset during a load.
        start_load();
        load_word(32'h1111_1111, 1'b0, 1'b0);
        load_word(32'h2222_2222, 1'b0, 1'b0);
        check("midload_wcount", WordCount, 2);
        Reset = 1;
        #2;
        check("midrst_ready",  Ready, 0);
        check("midrst_wcount", WordCount, 0);
        check("midrst_valid",  InstrValid, 0);
        tick();
        Reset = 0;
        fetch(0);
        check("postrst_fetch_valid", InstrValid, 0);

        // Parity: word 1 stored with an inverted parity bit.
`ifdef IMEM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        start_load();
        load_word(32'h0000_0003, 1'b0, 1'b0);
        load_word(32'h0000_0007, 1'b1, 1'b1);
        check("par_ready",  Ready, 1);
        check("par_wcount", WordCount, 2);
        fetch(1);
        check("par1_instr", Instruction, 32'h0000_0007);
        check("par1_perr",  ParityErr, exp_perr);
        fetch(0);
        check("par0_perr",  ParityErr, 0);
        check("par0_instr", Instruction, 32'h0000_0003);
        fetch(5);
        check("par_oor_perr",  ParityErr, 0);
        check("par_oor_fault", AddrFault, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised, loadable instruction memory for the pipelined MIPS fetch stage. Holds up to 2**ADDR_WIDTH words, loaded sequentially through a streaming load port with an auto-incrementing write pointer, and serves one registered fetch per cycle with a stall hold. Out-of-range fetches return a NOP and flag a fault. Sits between the PC register and the IF/ID pipeline register and replaces the fixed combinational instruction ROM.

## Interface
- ADDR_WIDTH, 7, word-address width; DEPTH = 2**ADDR_WIDTH (localparam)
- DATA_WIDTH, 32, instruction width
- NOP_WORD, 32'h0000_0000, word returned on faulted fetch (DATA_WIDTH bits)
- Clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- LoadStart  in  1  pulse: begin (or restart) a program load
- LoadValid  in  1  LoadData is valid this cycle
- LoadData  in  DATA_WIDTH  word to write at the write pointer
- LoadLast  in  1  marks final word of load (with or without LoadValid)
- ParityInject  in  1  flips stored parity bit of the word written this cycle (used only with IMEM_PARITY_EN)
- FetchReq  in  1  fetch request
- Address  in  ADDR_WIDTH  word address of fetch
- Stall  in  1  hold output register
- Instruction  out  DATA_WIDTH  fetched word (registered)
- InstrValid  out  1  Instruction valid
- AddrFault  out  1  fetch address >= WordCount
- ParityErr  out  1  parity mismatch on fetched word
- Ready  out  1  state is READY
- WordCount  out  ADDR_WIDTH+1  number of loaded words

## Operation
- States: EMPTY, LOAD, READY. Reset -> EMPTY.
- EMPTY: fetches ignored; LoadStart -> LOAD.
- LOAD: entered on LoadStart; pointer and WordCount cleared to 0. Each LoadValid writes LoadData at pointer, then pointer and WordCount increment. LoadStart in LOAD restarts (pointer=0, WordCount=0). LoadLast -> READY; a LoadValid in the same cycle is written first. A write at pointer DEPTH-1 auto-transitions to READY with WordCount=DEPTH.
- LoadStart cycle only arms: LoadValid/LoadLast in that same cycle are ignored.
- READY: FetchReq with Address < WordCount -> Instruction=mem[Address], AddrFault=0; otherwise Instruction=NOP_WORD, AddrFault=1. LoadValid/LoadLast ignored. LoadStart -> LOAD; a FetchReq in that cycle is ignored.
- Memory array not reset; contents survive Reset but WordCount=0, so nothing is fetchable until reloaded.

## Timing
- Reset values: Instruction=0, InstrValid=0, AddrFault=0, ParityErr=0, Ready=0, WordCount=0.
- Fetch latency 1 cycle: FetchReq sampled at edge N -> Instruction/InstrValid/AddrFault/ParityErr valid after edge N, held for one cycle.
- No FetchReq and Stall=0 -> InstrValid=0 next cycle, Instruction holds last value.
- Stall=1: all fetch outputs hold; FetchReq ignored (PC stage must re-present it).
- Ready rises the cycle after the LoadLast/auto-finish edge; first fetch may be issued that cycle.
- Leaving READY (LoadStart) clears InstrValid next cycle, regardless of Stall.
- Reset mid-load: immediate EMPTY; partial contents discarded (WordCount=0).

## Configuration
- IMEM_PARITY_EN defined: array is DATA_WIDTH+1 wide; even parity stored on write (inverted when ParityInject=1); checked on fetch; ParityErr=1 with InstrValid on mismatch, Instruction still delivered. Faulted fetches give ParityErr=0.
- Undefined: no parity bit stored; ParityErr tied 0; ParityInject ignored.

## Test plan
- Reset, LoadStart, 4 LoadValid words 0x20080005,0x20090007,0x01095020,0xAC0A0000 with LoadLast on 4th -> Ready=1, WordCount=4; fetch 0..3 -> same words, 1-cycle latency, AddrFault=0.
- Fetch Address=4 and 127 after above -> Instruction=0x00000000, AddrFault=1, InstrValid=1.
- Fetch 1 then Stall=1 for 3 cycles with FetchReq Address=2 -> Instruction holds 0x20090007; Stall=0 and re-request -> 0x01095020.
- Load 128 words (value = index) without LoadLast -> auto READY, WordCount=128; 129th LoadValid ignored; fetch 127 -> 127.
- Reset asserted mid-load after 2 words -> Ready=0, WordCount=0, InstrValid=0; fetch ignored until reload.
- IMEM_PARITY_EN: load word 1 with ParityInject=1 -> fetch 1 gives ParityErr=1, fetch 0 gives ParityErr=0; without macro ParityErr stays 0.
